// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the multi-cycle FSM and its datapath
//   master (controller): inputs start_i, Op_i, Zero_i, Mem_ready_i; outputs all strobes, selects, flags, State_o
//   slave (datapath/memory side): the mirror image
interface multicycle_control_if;
   logic       start_i;
   logic [5:0] Op_i;
   logic       Zero_i;
   logic       Mem_ready_i;
   logic       PCWrite_o;
   logic       PCWriteCond_o;
   logic [1:0] PCSrc_o;
   logic       IorD_o;
   logic       IRWrite_o;
   logic       Memread_o;
   logic       Memwrite_o;
   logic       Mem2reg_o;
   logic       RegDst_o;
   logic       RegWrite_o;
   logic       ALUSrcA_o;
   logic [1:0] ALUSrcB_o;
   logic [2:0] ALUOp_o;
   logic       Illegal_o;
   logic       Timeout_o;
   logic [3:0] State_o;
   modport master (
      input  start_i, Op_i, Zero_i, Mem_ready_i,
      output PCWrite_o, PCWriteCond_o, PCSrc_o, IorD_o, IRWrite_o, Memread_o, Memwrite_o,
             Mem2reg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, Illegal_o,
             Timeout_o, State_o
   );
   modport slave (
      output start_i, Op_i, Zero_i, Mem_ready_i,
      input  PCWrite_o, PCWriteCond_o, PCSrc_o, IorD_o, IRWrite_o, Memread_o, Memwrite_o,
             Mem2reg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, Illegal_o,
             Timeout_o, State_o
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a multi-cycle MIPS-subset datapath with memory-wait timeout
//   clk_i clock, rst_i synchronous active-low reset, bus master modport carrying start/opcode/zero/ready
//   in and all datapath strobes, selects, Illegal_o pulse, sticky Timeout_o and State_o out
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic               clk_i,
   input logic               rst_i,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDI, IWB, BRANCH, JUMP, HALT
   } state_t;
   localparam logic [7:0] LIM = 8'(MEM_TIMEOUT);
   state_t     state, nxt;
   logic [7:0] cnt;
   logic       timeout, mem_st, hit;
   state_t     fetch_nxt;
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= (mem_st && !bus.Mem_ready_i && nxt == state) ? cnt + 8'd1 : '0;
         timeout <= timeout | hit;
      end
   end
   always_comb begin
      bus.PCWrite_o     = 1'b0;
      bus.PCWriteCond_o = 1'b0;
      bus.PCSrc_o       = 2'b00;
      bus.IorD_o        = 1'b0;
      bus.IRWrite_o     = 1'b0;
      bus.Memread_o     = 1'b0;
      bus.Memwrite_o    = 1'b0;
      bus.Mem2reg_o     = 1'b0;
      bus.RegDst_o      = 1'b0;
      bus.RegWrite_o    = 1'b0;
      bus.ALUSrcA_o     = 1'b0;
      bus.ALUSrcB_o     = 2'b00;
      bus.ALUOp_o       = 3'b000;
      bus.Illegal_o     = 1'b0;
      fetch_nxt         = bus.start_i ? FETCH : IDLE;
      mem_st            = state inside {FETCH, MEMRD, MEMWR};
      hit               = mem_st && !bus.Mem_ready_i && cnt == LIM;
      nxt               = state;
      case (state)
         IDLE:   nxt = fetch_nxt;
         FETCH: begin
            bus.Memread_o = 1'b1;
            bus.ALUSrcB_o = 2'b01;
            bus.IRWrite_o = bus.Mem_ready_i;
            bus.PCWrite_o = bus.Mem_ready_i;
            nxt           = bus.Mem_ready_i ? DECODE : FETCH;
         end
         DECODE: begin
            bus.ALUSrcB_o = 2'b11;
            case (bus.Op_i)
               6'b000000:            nxt = EXEC;
               6'b100011, 6'b101011: nxt = MEMADR;
               6'b001000:            nxt = ADDI;
               6'b000100:            nxt = BRANCH;
               6'b000010:            nxt = JUMP;
               default: begin
                  bus.Illegal_o = 1'b1;
                  nxt           = fetch_nxt;
               end
            endcase
         end
         MEMADR: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUSrcB_o = 2'b10;
            nxt           = bus.Op_i == 6'b100011 ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.Memread_o = 1'b1;
            bus.IorD_o    = 1'b1;
            nxt           = bus.Mem_ready_i ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.RegWrite_o = 1'b1;
            bus.Mem2reg_o  = 1'b1;
            nxt            = fetch_nxt;
         end
         MEMWR: begin
            bus.Memwrite_o = 1'b1;
            bus.IorD_o     = 1'b1;
            nxt            = bus.Mem_ready_i ? fetch_nxt : MEMWR;
         end
         EXEC: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUOp_o   = 3'b111;
            nxt           = RWB;
         end
         RWB: begin
            bus.RegWrite_o = 1'b1;
            bus.RegDst_o   = 1'b1;
            nxt            = fetch_nxt;
         end
         ADDI: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUSrcB_o = 2'b10;
            nxt           = IWB;
         end
         IWB: begin
            bus.RegWrite_o = 1'b1;
            nxt            = fetch_nxt;
         end
         BRANCH: begin
            bus.ALUSrcA_o     = 1'b1;
            bus.ALUOp_o       = 3'b001;
            bus.PCWriteCond_o = 1'b1;
            bus.PCSrc_o       = 2'b01;
            nxt               = fetch_nxt;
         end
         JUMP: begin
            bus.PCWrite_o = 1'b1;
            bus.PCSrc_o   = 2'b10;
            nxt           = fetch_nxt;
         end
         HALT:    nxt = HALT;
         default: nxt = IDLE;
      endcase
      // a late ready wins over the limit, so hit already excludes Mem_ready_i=1
      if (hit) nxt = HALT;
      bus.Timeout_o = timeout;
      bus.State_o   = state;
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control (MEM_TIMEOUT=4)
module tb_multicycle_control;
   typedef struct {
      logic [3:0] st;
      logic       to;
      logic       r;
      logic [5:0] op;
      string      tag;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   multicycle_control_if bus ();
   multicycle_control #(.MEM_TIMEOUT(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [17:0] ctl(input logic [3:0] s, input logic r, input logic [5:0] op);
      logic pw, pwc, iord, irw, mr, mw, m2r, rd, rw, asa, ill;
      logic [1:0] pcs, asb;
      logic [2:0] aop;
      {pw, pwc, iord, irw, mr, mw, m2r, rd, rw, asa, ill} = '0;
      pcs = 2'b00;
      asb = 2'b00;
      aop = 3'b000;
      case (s)
         4'd1:  begin pw = r; irw = r; mr = 1'b1; asb = 2'b01; end
         4'd2:  begin asb = 2'b11; ill = !(op inside {6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h02}); end
         4'd3:  begin asa = 1'b1; asb = 2'b10; end
         4'd4:  begin mr = 1'b1; iord = 1'b1; end
         4'd5:  begin rw = 1'b1; m2r = 1'b1; end
         4'd6:  begin mw = 1'b1; iord = 1'b1; end
         4'd7:  begin asa = 1'b1; aop = 3'b111; end
         4'd8:  begin rw = 1'b1; rd = 1'b1; end
         4'd9:  begin asa = 1'b1; asb = 2'b10; end
         4'd10: rw = 1'b1;
         4'd11: begin asa = 1'b1; aop = 3'b001; pwc = 1'b1; pcs = 2'b01; end
         4'd12: begin pw = 1'b1; pcs = 2'b10; end
         default: ;
      endcase
      return {pw, pwc, pcs, iord, irw, mr, mw, m2r, rd, rw, asa, asb, aop, ill};
   endfunction
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, " state"}, 32'(bus.State_o), 32'(e.st));
         check({e.tag, " timeout"}, 32'(bus.Timeout_o), 32'(e.to));
         check({e.tag, " ctl"}, 32'({bus.PCWrite_o, bus.PCWriteCond_o, bus.PCSrc_o, bus.IorD_o,
               bus.IRWrite_o, bus.Memread_o, bus.Memwrite_o, bus.Mem2reg_o, bus.RegDst_o,
               bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o, bus.Illegal_o}),
               32'(ctl(e.st, e.r, e.op)));
      end
   end
   task automatic cy(input string tag, input logic s, input logic [5:0] op, input logic r,
                     input logic [3:0] es, input logic et);
      bus.start_i     = s;
      bus.Op_i        = op;
      bus.Mem_ready_i = r;
      sb.push_back('{st: es, to: et, r: r, op: op, tag: tag});
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst         = 1'b0;
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask
   initial begin
      bus.start_i     = 1'b0;
      bus.Op_i        = 6'h00;
      bus.Zero_i      = 1'b0;
      bus.Mem_ready_i = 1'b0;
      do_reset();
      cy("rst", 0, 6'h00, 1, 4'd0, 0);
      cy("rt", 1, 6'h00, 1, 4'd0, 0);
      cy("rt", 1, 6'h00, 1, 4'd1, 0);
      cy("rt", 1, 6'h00, 1, 4'd2, 0);
      cy("rt", 1, 6'h00, 1, 4'd7, 0);
      cy("rt", 1, 6'h00, 1, 4'd8, 0);
      cy("rt", 1, 6'h00, 1, 4'd1, 0);
      do_reset();
      cy("lw", 1, 6'h23, 1, 4'd0, 0);
      cy("lw", 1, 6'h23, 1, 4'd1, 0);
      cy("lw", 1, 6'h23, 1, 4'd2, 0);
      cy("lw", 1, 6'h23, 1, 4'd3, 0);
      for (int i = 0; i < 3; i++) cy("lw wait", 1, 6'h23, 0, 4'd4, 0);
      cy("lw", 1, 6'h23, 1, 4'd4, 0);
      cy("lw", 0, 6'h23, 1, 4'd5, 0);
      cy("lw", 0, 6'h23, 1, 4'd0, 0);
      do_reset();
      bus.Zero_i = 1'b1;
      cy("beq", 1, 6'h04, 1, 4'd0, 0);
      cy("beq", 1, 6'h04, 1, 4'd1, 0);
      cy("beq", 1, 6'h04, 1, 4'd2, 0);
      cy("beq", 1, 6'h04, 1, 4'd11, 0);
      cy("beq", 1, 6'h04, 1, 4'd1, 0);
      bus.Zero_i = 1'b0;
      cy("ill", 1, 6'h3f, 1, 4'd2, 0);
      cy("ill", 1, 6'h3f, 1, 4'd1, 0);
      cy("addi", 1, 6'h08, 1, 4'd2, 0);
      cy("addi", 1, 6'h08, 1, 4'd9, 0);
      cy("addi", 1, 6'h08, 1, 4'd10, 0);
      cy("j", 1, 6'h02, 1, 4'd1, 0);
      cy("j", 1, 6'h02, 1, 4'd2, 0);
      cy("j", 1, 6'h02, 1, 4'd12, 0);
      cy("sw", 1, 6'h2b, 1, 4'd1, 0);
      cy("sw", 1, 6'h2b, 1, 4'd2, 0);
      cy("sw", 0, 6'h2b, 1, 4'd3, 0);
      cy("sw wait", 0, 6'h2b, 0, 4'd6, 0);
      cy("sw wait", 0, 6'h2b, 0, 4'd6, 0);
      cy("sw", 0, 6'h2b, 1, 4'd6, 0);
      cy("sw stop", 0, 6'h2b, 1, 4'd0, 0);
      cy("sw stop", 0, 6'h2b, 1, 4'd0, 0);
      do_reset();
      cy("lim", 1, 6'h00, 0, 4'd0, 0);
      for (int i = 0; i < 4; i++) cy("lim wait", 1, 6'h00, 0, 4'd1, 0);
      cy("lim ready", 1, 6'h00, 1, 4'd1, 0);
      cy("lim ready", 1, 6'h00, 1, 4'd2, 0);
      do_reset();
      cy("to", 1, 6'h00, 0, 4'd0, 0);
      for (int i = 0; i < 5; i++) cy("to wait", 1, 6'h00, 0, 4'd1, 0);
      cy("to halt", 1, 6'h00, 1, 4'd13, 1);
      cy("to halt", 1, 6'h00, 1, 4'd13, 1);
      do_reset();
      cy("to rst", 0, 6'h00, 1, 4'd0, 0);
      cy("mid", 1, 6'h2b, 1, 4'd0, 0);
      cy("mid", 1, 6'h2b, 1, 4'd1, 0);
      cy("mid", 1, 6'h2b, 1, 4'd2, 0);
      cy("mid", 1, 6'h2b, 1, 4'd3, 0);
      cy("mid", 1, 6'h2b, 0, 4'd6, 0);
      do_reset();
      cy("mid rst", 0, 6'h2b, 0, 4'd0, 0);
      @(negedge clk);
      check("sb drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multi-cycle MIPS-subset datapath: single memory, shared ALU, IR/A/B/ALUOut/MDR holding registers.
- Replaces the single-cycle decoder for the multi-cycle core.
- Decodes Op_i per instruction and drives one datapath step per state.
- Waits on a memory ready handshake, with timeout supervision.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent waiting for Mem_ready_i in any memory state before aborting; must be 1..255.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-low reset.
- start_i  input  1  level; core runs while high.
- Op_i  input  6  IR[31:26], valid from DECODE onward.
- Zero_i  input  1  ALU zero flag.
- Mem_ready_i  input  1  memory access complete this cycle.
- PCWrite_o  output  1  unconditional PC load.
- PCWriteCond_o  output  1  PC load if Zero_i.
- PCSrc_o  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD_o  output  1  memory address: 0 PC, 1 ALUOut.
- IRWrite_o  output  1  load IR.
- Memread_o  output  1  memory read request.
- Memwrite_o  output  1  memory write request.
- Mem2reg_o  output  1  write-back source: 1 MDR, 0 ALUOut.
- RegDst_o  output  1  destination select: 1 rd, 0 rt.
- RegWrite_o  output  1  register file write.
- ALUSrcA_o  output  1  ALU A: 0 PC, 1 reg A.
- ALUSrcB_o  output  2  ALU B: 00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2.
- ALUOp_o  output  3  000 add, 001 sub, 111 R-type (funct decode).
- Illegal_o  output  1  one-cycle pulse, unsupported opcode.
- Timeout_o  output  1  sticky memory-timeout flag.
- State_o  output  4  current state encoding, for debug.

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, ADDI=9, IWB=10, BRANCH=11, JUMP=12, HALT=13.
- Reset (rst_i=0 at posedge): state IDLE, timeout counter 0, Timeout_o 0.
- In IDLE, every output is 0, including State_o=0. An output not listed for a state is 0.
- IDLE: if start_i=1, go to FETCH; otherwise stay.
- FETCH:
  - Memread=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00.
  - IRWrite and PCWrite equal Mem_ready_i (Mealy).
  - If Mem_ready_i=1, go to DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Next state by Op_i:
  - 000000 → EXEC.
  - 100011 or 101011 → MEMADR.
  - 001000 → ADDI.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - Any other opcode: Illegal_o=1 this cycle, then FETCH. No register or memory write occurs.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Go to MEMRD if Op_i=100011, else MEMWR.
- MEMRD: Memread=1, IorD=1. If Mem_ready_i=1, go to MEMWB.
- MEMWB: RegWrite=1, Mem2reg=1, RegDst=0. Go to FETCH.
- MEMWR:
  - Memwrite=1, IorD=1.
  - If Mem_ready_i=1, go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Go to RWB.
- RWB: RegWrite=1, RegDst=1, Mem2reg=0. Go to FETCH.
- ADDI: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Go to IWB.
- IWB: RegWrite=1, RegDst=0, Mem2reg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSrc=01. Go to FETCH.
- JUMP: PCWrite=1, PCSrc=10. Go to FETCH.
- start_i sampled only at each FETCH entry: if start_i=0 when a state would go to FETCH, go to IDLE instead. An instruction in flight always completes.
- Memory wait timeout:
  - Applies in FETCH, MEMRD and MEMWR; an 8-bit counter increments each cycle Mem_ready_i=0.
  - The counter clears on state change and on Mem_ready_i=1.
  - When the counter equals MEM_TIMEOUT with Mem_ready_i still 0: go to HALT and set Timeout_o=1.
  - Mem_ready_i=1 in the same cycle as the limit wins: normal transition, no timeout.
- HALT: all strobes 0. Stay until reset; Timeout_o stays 1 until reset.
- Reset mid-instruction, e.g. in MEMWR with Memwrite=1: the next cycle is IDLE with every output 0. No partial write-back strobe is emitted.
- Latencies with zero-wait memory: R-type 4 cycles, lw 5, sw 4, addi 4, beq 3, j 3.

Test Plan:
- Reset, start_i=1, Mem_ready_i=1, Op_i=000000 → State_o 1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. IRWrite=PCWrite=1 in state 1.
- lw (100011), Mem_ready_i low 3 cycles in MEMRD → MEMRD held 4 cycles with Memread=1, IorD=1, then MEMWB with RegWrite=1 and Mem2reg=1.
- beq (000100) with Zero_i=1 → BRANCH: ALUOp=001, PCWriteCond=1, PCSrc=01. Total 3 cycles from the first FETCH cycle.
- Op_i=111111 at DECODE → Illegal_o pulses exactly 1 cycle, next state FETCH, RegWrite and Memwrite never asserted.
- MEM_TIMEOUT=4, Mem_ready_i held 0 in FETCH → HALT after 5 FETCH cycles, Timeout_o=1 and sticky. Then rst_i=0 for 1 cycle → IDLE, Timeout_o=0.
- start_i dropped during sw → MEMWR completes (Memwrite=1 until Mem_ready_i), then IDLE and no further FETCH.
